// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: FSM state codes, op width and
// the bit layout of the packed response word.
package alu_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned N_DEFAULT = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t RESP = 2'd2;

  // rsp_data = {zero, overflow, carry, result[N-1:0]}; flag offsets are relative to N
  localparam int unsigned RSP_RESULT_LSB = 0;
  localparam int unsigned RSP_CARRY_REL  = 0;
  localparam int unsigned RSP_OVF_REL    = 1;
  localparam int unsigned RSP_ZERO_REL   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On contention the requester not granted last wins;
// the pointer moves only when a grant is issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // Id of the most recent grant; reset to 1 so requester 0 wins the first contention.
  logic last_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/alu_arb.sv
// Arbitrates two requesters onto one external ALU: grant in IDLE, drive the ALU for
// one cycle in EXEC, then hold the captured result in RESP until it is consumed.
module alu_arb
  import alu_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_op,
  input  logic [2*N-1:0]    req_a,
  input  logic [2*N-1:0]    req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [N+2:0]      rsp_data,
  output logic              alu_en,
  output logic [OP_W-1:0]   alu_op,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic              busy
);

  state_t          state_q, state_d;
  logic [1:0]      grant;
  logic            arb_en;
  logic            accept;
  logic            acc_id;
  logic [OP_W-1:0] op_q;
  logic [N-1:0]    a_q, b_q;
  logic            id_q;
  logic [N+2:0]    rsp_data_q;
  logic [N+2:0]    alu_pack;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid (req_valid),
    .grant (grant)
  );

  // Grant only ever names a valid requester, so a grant is an acceptance.
  assign req_ready = grant;
  assign accept    = |grant;
  assign acc_id    = grant[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_pack                          = '0;
    alu_pack[RSP_RESULT_LSB +: N]     = alu_result;
    alu_pack[N + RSP_CARRY_REL]       = alu_carry;
    alu_pack[N + RSP_OVF_REL]         = alu_overflow;
    alu_pack[N + RSP_ZERO_REL]        = alu_zero;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= acc_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
        a_q  <= acc_id ? req_a[2*N-1:N] : req_a[N-1:0];
        b_q  <= acc_id ? req_b[2*N-1:N] : req_b[N-1:0];
        id_q <= acc_id;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_pack;
      end
    end
  end

  assign alu_en    = (state_q == EXEC);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/result width, matching the shared Alu datapath.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-005 SHALL have port req_ready  out  2  per-requester accept; at most one bit high.
REQ-006 SHALL have port req_op  in  6  {op1[2:0], op0[2:0]}, Alu op code per requester.
REQ-007 SHALL have port req_a  in  2N  {a1, a0} operand A per requester.
REQ-008 SHALL have port req_b  in  2N  {b1, b0} operand B per requester.
REQ-009 SHALL have port rsp_valid  out  1  response valid.
REQ-010 SHALL have port rsp_ready  in  1  response consumer ready.
REQ-011 SHALL have port rsp_id  out  1  requester index owning the response.
REQ-012 SHALL have port rsp_data  out  N+3  {zero, overflow, carry, result[N-1:0]}.
REQ-013 SHALL have port alu_en, alu_op[2:0], alu_a[N-1:0], alu_b[N-1:0]  out  enable/op/operands to the Alu.
REQ-014 SHALL have port alu_result[N-1:0], alu_carry, alu_overflow, alu_zero  in  Alu outputs.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other transitions except reset.
REQ-017 In IDLE, SHALL grant one valid requester round-robin: the requester not granted last wins on contention; a sole requester always wins.
REQ-018 req_ready[i] SHALL be high only in IDLE for the granted i (combinational from req_valid); acceptance = req_valid[i] & req_ready[i], moving IDLE -> EXEC and latching op, A, B, id.
REQ-019 In EXEC (exactly one cycle), SHALL drive alu_en=1 with latched op/A/B and capture alu_result/carry/overflow/zero into rsp_data at cycle end; move to RESP.
REQ-020 Outside EXEC, alu_en SHALL be 0; alu_op/alu_a/alu_b SHALL hold last latched values.
REQ-021 In RESP, rsp_valid SHALL be 1 with rsp_id/rsp_data stable until rsp_ready sampled high; then IDLE and rsp_valid=0 the next cycle.
REQ-022 Latency: acceptance at cycle t -> rsp_valid first high at t+2; max throughput one op per 3 cycles.
REQ-023 Round-robin pointer SHALL update only on acceptance, to the accepted id.
REQ-024 Requests arriving in EXEC/RESP SHALL be held off (req_ready=00), never dropped or reordered within a requester.
REQ-025 rsp_ready high while not in RESP SHALL have no effect.

Reset
REQ-026 On rst: state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, alu_en=0, alu_op/a/b=0, busy=0, pointer set so requester 0 wins first contention.
REQ-027 rst in EXEC or RESP SHALL abort the operation; no response for it is ever produced.
REQ-028 rst SHALL dominate all other inputs in the same cycle.

Structure
REQ-029 A shared package alu_pkg SHALL hold the state enum (IDLE, EXEC, RESP), OP_W=3, default N=4, and the rsp_data field offsets.
REQ-030 The grant logic SHALL be one sub-module rr_arb2 (2-way round-robin, pointer inside); the Alu SHALL stay external.

Verification
REQ-031 Reset then req_valid=01, op0=000 (add), a0=3, b0=4 -> req_ready=01 at t, alu_en=1 at t+1, rsp_valid at t+2 with id=0, data={0,0,0,0111}.
REQ-032 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, each response 3 cycles apart with matching id.
REQ-033 op=000, A=7, B=1 -> data overflow=1, result=1000; op=001 (sub), A=5, B=5 -> zero=1, result=0000.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable throughout; req_ready=00; alu_en=0.
REQ-035 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, no response emitted; next contention grants requester 0.
REQ-036 Requester 1 alone, 3 back-to-back ops -> all accepted and returned in order, id=1.
